tiny8_mem_responder: RTL and testbench

Memory-side responder for the tiny8 CPU memory interface. The control FSM raises `mem_read` or `mem_write` with an address and holds it until `mem_resp`. This block accepts the request, waits a configurable number of cycles, then performs the access on an internal byte-wide storage array. It returns a one-cycle `mem_resp` pulse, with read data, and sits between the datapath's address/data muxes and the (modelled) memory.

---
 rtl/tiny8_mem_responder.sv | 119 +++++++++++
 tb/tb_tiny8_mem_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tiny8_mem_responder.sv
// rtl/tiny8_mem_responder.sv - latency-configurable byte memory responder for the tiny8 memory interface
// Optional macro TINY8_MEM_CLR_EN: reset also clears the storage array.
module tiny8_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_resp
);

    localparam int         DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    is_write_q, is_write_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    resp_q, resp_d;
    logic                    do_access;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
            resp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
        end
    end

    // WAIT holds LATENCY+1 cycles: the cycle whose count is zero is the access edge.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_d    = WAIT;
                    wait_cnt_d = LAT;
                    addr_d     = mem_address;
                    wdata_d    = mem_wdata;
                    is_write_d = mem_write;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        do_access = (state_q == WAIT) && (wait_cnt_q == 4'd0);
        mem_we    = do_access && is_write_q;
        resp_d    = do_access;
        rdata_d   = rdata_q;
        if (do_access && !is_write_q) begin
            rdata_d = mem[addr_q];
        end
    end

`ifdef TINY8_MEM_CLR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end
`endif

    assign mem_rdata = rdata_q;
    assign mem_resp  = resp_q;

endmodule

// File: tb/tb_tiny8_mem_responder.sv
// tb/tb_tiny8_mem_responder.sv - directed table-driven bench for tiny8_mem_responder at LATENCY 2, 0 and 3
module tb_tiny8_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n [3];
    logic       rd    [3];
    logic       wr    [3];
    logic [7:0] addr  [3];
    logic [7:0] wdata [3];
    logic [7:0] rdata [3];
    logic       resp  [3];

    int lat [3] = '{2, 0, 3};
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tiny8_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n[0]), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_address(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_resp(resp[0]));

    tiny8_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n[1]), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_address(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_resp(resp[1]));

    tiny8_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n[2]), .mem_read(rd[2]), .mem_write(wr[2]),
        .mem_address(addr[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_resp(resp[2]));

    typedef struct {
        int         inst;
        bit         r;
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        bit         chk;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [10];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Count falling edges until mem_resp is seen; -1 if it never comes.
    task automatic wait_resp(int i, output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (resp[i]) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic req(int i, bit r, bit w, logic [7:0] a, logic [7:0] d, output int cyc);
        rd[i]    = r;
        wr[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        wait_resp(i, cyc);
    endtask

    task automatic finish_req(int i);
        rd[i] = 1'b0;
        wr[i] = 1'b0;
        @(negedge clk);
        check("resp_width", int'(resp[i]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pulses;

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            rd[i]    = 1'b0;
            wr[i]    = 1'b0;
            addr[i]  = 8'h00;
            wdata[i] = 8'h00;
        end

        tbl[0] = '{0, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00};
        tbl[1] = '{0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5};
        tbl[2] = '{0, 1'b0, 1'b1, 8'hFF, 8'h01, 1'b0, 8'h00};
        tbl[3] = '{0, 1'b0, 1'b1, 8'h00, 8'hFE, 1'b0, 8'h00};
        tbl[4] = '{0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h01};
        tbl[5] = '{0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFE};
        tbl[6] = '{0, 1'b1, 1'b1, 8'h20, 8'h77, 1'b1, 8'hFE};
        tbl[7] = '{0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h77};
        tbl[8] = '{2, 1'b0, 1'b1, 8'h05, 8'h11, 1'b0, 8'h00};
        tbl[9] = '{2, 1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'h11};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_resp", int'(resp[i]), 0);
            check("reset_rdata", int'(rdata[i]), 0);
            rst_n[i] = 1'b1;
        end
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            req(tbl[v].inst, tbl[v].r, tbl[v].w, tbl[v].a, tbl[v].d, cyc);
            check("latency", cyc, lat[tbl[v].inst] + 2);
            if (tbl[v].chk) begin
                check("rdata", int'(rdata[tbl[v].inst]), int'(tbl[v].exp_rd));
            end
            finish_req(tbl[v].inst);
        end

        // Back-to-back at LATENCY=0: the read is already presented during RESP.
        req(1, 1'b0, 1'b1, 8'hFF, 8'h3C, cyc);
        check("b2b_first_latency", cyc, 2);
        req(1, 1'b1, 1'b0, 8'hFF, 8'h00, cyc);
        check("b2b_second_gap", cyc, 3);
        check("b2b_rdata", int'(rdata[1]), 8'h3C);
        finish_req(1);

        // Address and data change during WAIT must not affect the latched write.
        req(0, 1'b0, 1'b1, 8'h11, 8'h44, cyc);
        finish_req(0);
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 8'h10; wdata[0] = 8'h99;
        @(negedge clk);
        addr[0] = 8'h11; wdata[0] = 8'h55;
        wait_resp(0, cyc);
        check("chg_latency", cyc, 3);
        finish_req(0);
        req(0, 1'b1, 1'b0, 8'h10, 8'h00, cyc);
        check("chg_rdata_10", int'(rdata[0]), 8'h99);
        finish_req(0);
        req(0, 1'b1, 1'b0, 8'h11, 8'h00, cyc);
        check("chg_rdata_11", int'(rdata[0]), 8'h44);
        finish_req(0);

        // Reset mid-WAIT at LATENCY=3 drops the write of 0x66.
        wr[2] = 1'b1; addr[2] = 8'h05; wdata[2] = 8'h66;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n[2] = 1'b0;
        #1;
        check("rst_async_resp", int'(resp[2]), 0);
        check("rst_async_rdata", int'(rdata[2]), 0);
        wr[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n[2] = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp[2]) pulses++;
        end
        check("dropped_resp", pulses, 0);
        req(2, 1'b1, 1'b0, 8'h05, 8'h00, cyc);
        check("rst_latency", cyc, 5);
`ifdef TINY8_MEM_CLR_EN
        check("dropped_write", int'(rdata[2]), 8'h00);
`else
        check("dropped_write", int'(rdata[2]), 8'h11);
`endif
        finish_req(2);

        // Storage across reset.
        req(0, 1'b0, 1'b1, 8'h01, 8'h5A, cyc);
        finish_req(0);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        req(0, 1'b1, 1'b0, 8'h01, 8'h00, cyc);
        check("clr_latency", cyc, 4);
`ifdef TINY8_MEM_CLR_EN
        check("clr_rdata", int'(rdata[0]), 8'h00);
`else
        check("clr_rdata", int'(rdata[0]), 8'h5A);
`endif
        finish_req(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
